// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Sits between EX and MEM. Non-branch ALU results go into a 2-entry in-order
//   buffer that feeds MEM through a valid/ready handshake. Branches are
//   resolved here and never enter the buffer. A taken branch raises
//   redirect_valid and redirect_pc for the cycle after it is accepted.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   in_valid / in_ready     upstream handshake; in_ready = (count < 2)
//   alu_c, alu_compare      ALU result and its zero flag
//   branch_type, branch_target   branch kind (000 none, 001 BNE, 010 BEQ,
//                           011 BGZ, 100 BLZ, others none) and taken target
//   in_dest, in_reg_write, in_mem_read, in_mem_write, in_store_data
//                           fields carried with a non-branch entry
//   flush                   synchronous kill of held and incoming entries
//   out_valid / out_ready   downstream handshake for the head entry
//   out_result, out_store_data, out_dest, out_reg_write, out_mem_read,
//   out_mem_write           head-entry fields; control bits are 0 when idle
//   redirect_valid, redirect_pc  one-cycle taken-branch redirect
module ex_mem_stage #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] alu_c,
  input  logic                 alu_compare,
  input  logic [2:0]           branch_type,
  input  logic [WORD_SIZE-1:0] branch_target,
  input  logic [1:0]           in_dest,
  input  logic                 in_reg_write,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic [WORD_SIZE-1:0] in_store_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_result,
  output logic [WORD_SIZE-1:0] out_store_data,
  output logic [1:0]           out_dest,
  output logic                 out_reg_write,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BNE  = 3'b001,
    BR_BEQ  = 3'b010,
    BR_BGZ  = 3'b011,
    BR_BLZ  = 3'b100
  } br_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] result;
    logic [WORD_SIZE-1:0] store_data;
    logic [1:0]           dest;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
  } entry_t;

  entry_t     head_q;
  entry_t     tail_q;
  entry_t     in_entry;
  logic [1:0] count_q;

  logic is_branch;
  logic taken;
  logic accept;
  logic push;
  logic pop;
  logic fire_redirect;

  // Branch resolution from the ALU flags; the sign bit is the result MSB.
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    case (branch_type)
      BR_BNE: begin
        is_branch = 1'b1;
        taken     = !alu_compare;
      end
      BR_BEQ: begin
        is_branch = 1'b1;
        taken     = alu_compare;
      end
      BR_BGZ: begin
        is_branch = 1'b1;
        taken     = !alu_c[WORD_SIZE-1] && !alu_compare;
      end
      BR_BLZ: begin
        is_branch = 1'b1;
        taken     = alu_c[WORD_SIZE-1];
      end
      default: begin
        is_branch = 1'b0;
        taken     = 1'b0;
      end
    endcase
  end

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);

  assign accept        = in_valid && in_ready;
  assign push          = accept && !is_branch;
  assign pop           = out_valid && out_ready;
  assign fire_redirect = accept && is_branch && taken && !flush;

  always_comb begin
    in_entry            = '0;
    in_entry.result     = alu_c;
    in_entry.store_data = in_store_data;
    in_entry.dest       = in_dest;
    in_entry.reg_write  = in_reg_write;
    in_entry.mem_read   = in_mem_read;
    in_entry.mem_write  = in_mem_write;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // The pulse is recomputed every edge, so a flush only suppresses the
      // redirect of the entry arriving with it, not one already on the wire.
      redirect_valid <= fire_redirect;
      if (fire_redirect) begin
        redirect_pc <= branch_target;
      end

      if (flush) begin
        count_q <= '0;
      end else if (push && !pop) begin
        if (count_q == 2'd0) begin
          head_q <= in_entry;
        end else begin
          tail_q <= in_entry;
        end
        count_q <= count_q + 2'd1;
      end else if (push && pop) begin
        // push needs count < 2 and pop needs count > 0, so count is 1:
        // the new entry replaces the departing head and count is unchanged.
        head_q <= in_entry;
      end else if (pop) begin
        head_q  <= tail_q;
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign out_result     = head_q.result;
  assign out_store_data = head_q.store_data;
  assign out_dest       = head_q.dest;
  assign out_reg_write  = out_valid && head_q.reg_write;
  assign out_mem_read   = out_valid && head_q.mem_read;
  assign out_mem_write  = out_valid && head_q.mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_c;
  logic        alu_compare;
  logic [2:0]  branch_type;
  logic [15:0] branch_target;
  logic [1:0]  in_dest;
  logic        in_reg_write;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [15:0] in_store_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [15:0] out_store_data;
  logic [1:0]  out_dest;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  ex_mem_stage #(.WORD_SIZE(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_c          (alu_c),
    .alu_compare    (alu_compare),
    .branch_type    (branch_type),
    .branch_target  (branch_target),
    .in_dest        (in_dest),
    .in_reg_write   (in_reg_write),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_store_data  (in_store_data),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_dest       (out_dest),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] res;
    logic [15:0] sd;
    logic [1:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
  } ent_t;

  ent_t        mq[$];
  bit          m_rv;
  logic [15:0] m_rpc;

  function automatic bit is_br(input logic [2:0] bt);
    return (bt >= 3'd1) && (bt <= 3'd4);
  endfunction

  function automatic bit br_taken(input logic [2:0] bt, input logic [15:0] c, input logic cmp);
    case (bt)
      3'd1:    return !cmp;
      3'd2:    return cmp;
      3'd3:    return !c[15] && !cmp;
      3'd4:    return c[15];
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge reset_n) begin
    mq.delete();
    m_rv  = 1'b0;
    m_rpc = '0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      bit   acc;
      bit   popm;
      ent_t e;
      acc  = in_valid && (mq.size() < 2);
      popm = (mq.size() > 0) && out_ready;
      m_rv = acc && is_br(branch_type) && br_taken(branch_type, alu_c, alu_compare) && !flush;
      if (m_rv) m_rpc = branch_target;
      if (flush) begin
        mq.delete();
      end else begin
        if (popm) void'(mq.pop_front());
        if (acc && !is_br(branch_type)) begin
          e.res  = alu_c;
          e.sd   = in_store_data;
          e.dest = in_dest;
          e.rw   = in_reg_write;
          e.mr   = in_mem_read;
          e.mw   = in_mem_write;
          mq.push_back(e);
        end
      end
    end
  end

  // ---------------- cycle-by-cycle compare ----------------
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    if (m_rv) chk("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
    if (mq.size() != 0) begin
      chk("out_result", 32'(out_result), 32'(mq[0].res));
      chk("out_store_data", 32'(out_store_data), 32'(mq[0].sd));
      chk("out_dest", 32'(out_dest), 32'(mq[0].dest));
      chk("out_ctrl", 32'({out_reg_write, out_mem_read, out_mem_write}),
          32'({mq[0].rw, mq[0].mr, mq[0].mw}));
    end else begin
      chk("out_ctrl_idle", 32'({out_reg_write, out_mem_read, out_mem_write}), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    in_valid      = 1'b0;
    alu_c         = '0;
    alu_compare   = 1'b0;
    branch_type   = 3'd0;
    branch_target = '0;
    in_dest       = '0;
    in_reg_write  = 1'b0;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_store_data = '0;
    flush         = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_data(input logic [15:0] c, input logic [1:0] d);
    idle();
    in_valid     = 1'b1;
    alu_c        = c;
    in_dest      = d;
    in_reg_write = 1'b1;
  endtask

  task automatic push_br(input logic [2:0] bt, input logic [15:0] c, input logic cmp,
                         input logic [15:0] tgt);
    idle();
    in_valid      = 1'b1;
    branch_type   = bt;
    alu_c         = c;
    alu_compare   = cmp;
    branch_target = tgt;
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 3) != 0);
    case ($urandom_range(0, 3))
      0:       alu_c = 16'h0000;
      1:       alu_c = 16'h8000;
      default: alu_c = 16'($urandom);
    endcase
    alu_compare   = 1'($urandom);
    branch_type   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    branch_target = 16'($urandom);
    in_dest       = 2'($urandom);
    in_reg_write  = 1'($urandom);
    in_mem_read   = 1'($urandom);
    in_mem_write  = 1'($urandom);
    in_store_data = 16'($urandom);
    flush         = ($urandom_range(0, 19) == 0);
    out_ready     = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    idle();
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_redirect", 32'({redirect_valid, redirect_pc}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // basic single transfer
    out_ready = 1'b1;
    push_data(16'h1234, 2'd2);
    cyc();
    idle();
    chk("t033_valid", 32'(out_valid), 32'd1);
    chk("t033_result", 32'(out_result), 32'h1234);
    chk("t033_dest", 32'(out_dest), 32'd2);
    cyc();
    chk("t033_drain", 32'(out_valid), 32'd0);

    // fill, overflow attempt, ordered drain
    out_ready = 1'b0;
    push_data(16'h0001, 2'd1);
    cyc();
    push_data(16'h0002, 2'd3);
    cyc();
    chk("t034_full", 32'(in_ready), 32'd0);
    push_data(16'h0003, 2'd0);
    cyc();
    idle();
    chk("t034_head_a", 32'(out_result), 32'h0001);
    out_ready = 1'b1;
    cyc();
    chk("t034_head_b", 32'(out_result), 32'h0002);
    chk("t034_valid_b", 32'(out_valid), 32'd1);
    cyc();
    chk("t034_empty", 32'(out_valid), 32'd0);

    // BEQ taken / not taken
    push_br(3'b010, 16'h0000, 1'b1, 16'h0040);
    cyc();
    idle();
    chk("t035_rv", 32'(redirect_valid), 32'd1);
    chk("t035_pc", 32'(redirect_pc), 32'h0040);
    chk("t035_noentry", 32'(out_valid), 32'd0);
    push_br(3'b010, 16'h0005, 1'b0, 16'h0050);
    cyc();
    idle();
    chk("t035_nt", 32'(redirect_valid), 32'd0);

    // BGZ / BLZ sign handling
    push_br(3'b011, 16'h8000, 1'b0, 16'h0060);
    cyc();
    chk("t036_bgz_neg", 32'(redirect_valid), 32'd0);
    push_br(3'b100, 16'h8000, 1'b0, 16'h0070);
    cyc();
    chk("t036_blz", 32'(redirect_valid), 32'd1);
    chk("t036_blz_pc", 32'(redirect_pc), 32'h0070);
    push_br(3'b011, 16'h0000, 1'b1, 16'h0080);
    cyc();
    idle();
    chk("t036_bgz_zero", 32'(redirect_valid), 32'd0);

    // back-to-back taken branches
    push_br(3'b001, 16'h0003, 1'b0, 16'h0010);
    cyc();
    chk("t030_first_pc", 32'(redirect_pc), 32'h0010);
    push_br(3'b100, 16'hffff, 1'b0, 16'h0020);
    cyc();
    idle();
    chk("t030_second_rv", 32'(redirect_valid), 32'd1);
    chk("t030_second_pc", 32'(redirect_pc), 32'h0020);

    // flush does not cancel a pulse already on the wire
    push_br(3'b100, 16'h8001, 1'b0, 16'h0077);
    cyc();
    idle();
    flush = 1'b1;
    chk("t029_pulse_kept", 32'(redirect_valid), 32'd1);
    cyc();
    idle();
    chk("t029_pulse_end", 32'(redirect_valid), 32'd0);

    // flush with two held entries and a taken branch arriving
    out_ready = 1'b0;
    push_data(16'h00aa, 2'd1);
    cyc();
    push_data(16'h00bb, 2'd2);
    cyc();
    push_br(3'b010, 16'h0000, 1'b1, 16'h0099);
    flush = 1'b1;
    cyc();
    idle();
    chk("t037_valid", 32'(out_valid), 32'd0);
    chk("t037_ready", 32'(in_ready), 32'd1);
    chk("t037_norv", 32'(redirect_valid), 32'd0);

    // asynchronous reset between edges
    push_data(16'h0bad, 2'd3);
    cyc();
    idle();
    chk("t038_held", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("t038_async_drop", 32'(out_valid), 32'd0);
    #1 reset_n = 1'b1;
    cyc();
    chk("t038_empty", 32'(out_valid), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ((i % 700) == 350) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      rand_inputs();
      cyc();
    end

    idle();
    out_ready = 1'b1;
    cyc();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: WORD_SIZE, 16, datapath width; all data ports below are WORD_SIZE bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  ALU result and its control fields are presented this cycle.
REQ-005 in_ready  output  1  stage accepts an entry this cycle; a transfer occurs when in_valid && in_ready at the edge.
REQ-006 alu_c  input  16  ALU result C.
REQ-007 alu_compare  input  1  ALU Compare flag, high when the arithmetic result is zero.
REQ-008 branch_type  input  3  000 none, 001 BNE, 010 BEQ, 011 BGZ, 100 BLZ; 101-111 treated as none.
REQ-009 branch_target  input  16  PC to load if the branch is taken.
REQ-010 in_dest  input  2  destination register index.
REQ-011 in_reg_write, in_mem_read, in_mem_write  input  1 each  downstream control bits.
REQ-012 in_store_data  input  16  store operand for memory writes.
REQ-013 flush  input  1  synchronous kill of all held and incoming entries.
REQ-014 out_valid  output  1  head entry is presented downstream.
REQ-015 out_ready  input  1  downstream consumes the head entry when out_valid && out_ready at the edge.
REQ-016 out_result, out_store_data  output  16 each; out_dest  output  2; out_reg_write, out_mem_read, out_mem_write  output  1 each  head-entry fields.
REQ-017 redirect_valid  output  1  one-cycle pulse, taken branch resolved.
REQ-018 redirect_pc  output  16  target PC, meaningful only while redirect_valid is high.

Function
REQ-019 The stage SHALL hold a 2-entry in-order buffer; in_ready SHALL equal (count < 2), driven from registered state only.
REQ-020 Latency SHALL be one cycle: an entry accepted at edge N SHALL appear on out_* after edge N if the buffer was empty.
REQ-021 Branch decision SHALL be: BNE taken = !alu_compare; BEQ taken = alu_compare; BGZ taken = !alu_c[15] && !alu_compare; BLZ taken = alu_c[15].
REQ-022 An accepted entry with branch_type 001-100 SHALL NOT enter the buffer; if taken, redirect_valid=1 and redirect_pc=branch_target for exactly the cycle after acceptance; if not taken, no output effect.
REQ-023 An accepted entry with branch_type none SHALL be written to the buffer tail with all data and control fields unchanged.
REQ-024 Output fields SHALL come from the head entry; when out_valid=0, out_reg_write, out_mem_read and out_mem_write SHALL be 0.
REQ-025 Simultaneous pop and push with count=1 SHALL leave count=1, with the new entry at the head on the next cycle.
REQ-026 Pop with count=2 SHALL promote entry 1 to head, preserving order.
REQ-027 Head fields SHALL be stable while out_valid && !out_ready.
REQ-028 flush SHALL take priority: on a flush edge count becomes 0, the incoming entry is discarded, and no redirect is generated for it.
REQ-029 flush SHALL NOT cancel a redirect_valid pulse already being driven in the flush cycle.
REQ-030 Redirects from consecutive accepted taken branches SHALL produce consecutive pulses, each carrying its own target.

Reset
REQ-031 While reset_n=0: count=0, out_valid=0, redirect_valid=0, redirect_pc=0, all buffered fields=0, in_ready=1 after release.
REQ-032 Reset asserted mid-transfer SHALL discard all entries and any pending redirect immediately, without waiting for clk.

Verification
REQ-033 Reset, then in_valid with alu_c=16'h1234, in_dest=2, in_reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=16'h1234, out_dest=2.
REQ-034 out_ready=0; push A=16'h0001 then B=16'h0002 -> in_ready=0; third push is ignored; release out_ready -> outputs 0001 then 0002 in order.
REQ-035 BEQ with alu_compare=1, branch_target=16'h0040 -> one-cycle redirect_valid, redirect_pc=16'h0040, out_valid stays 0; BEQ with alu_compare=0 -> no redirect.
REQ-036 BGZ with alu_c=16'h8000 -> not taken; BLZ with alu_c=16'h8000 -> taken; BGZ with alu_c=0, alu_compare=1 -> not taken.
REQ-037 Two entries held, then flush concurrent with in_valid -> next cycle out_valid=0, in_ready=1, no redirect.
REQ-038 reset_n pulsed low between clock edges with one entry held -> out_valid drops immediately; after release the buffer is empty.
